// File: rtl/tcdm_router_pkg.sv
// Shared types and width helpers for the TCDM request router.
// Address fields are decoded into a wide struct and narrowed by the user.
package tcdm_router_pkg;

    typedef enum logic {
        LOCAL  = 1'b0,
        REMOTE = 1'b1
    } dest_e;

    localparam int unsigned MaxFieldBits = 64;

    typedef struct packed {
        logic [MaxFieldBits-1:0] tile;
        logic [MaxFieldBits-1:0] bank;
        logic [MaxFieldBits-1:0] row;
    } addr_fields_t;

    function automatic int unsigned tile_id_bits(input int unsigned num_tiles);
        return $clog2(num_tiles);
    endfunction

    function automatic int unsigned bank_offset_bits(input int unsigned num_banks);
        return $clog2(num_banks);
    endfunction

    function automatic int unsigned row_bits(input int unsigned addr_width,
                                             input int unsigned byte_offset,
                                             input int unsigned num_tiles,
                                             input int unsigned num_banks);
        return addr_width - byte_offset - $clog2(num_banks) - $clog2(num_tiles);
    endfunction

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

    // Fields above the row width come out zero because the address is zero-extended.
    function automatic addr_fields_t decode_addr(input logic [MaxFieldBits-1:0] addr,
                                                 input int unsigned byte_offset,
                                                 input int unsigned bank_bits,
                                                 input int unsigned tile_bits);
        addr_fields_t            f;
        logic [MaxFieldBits-1:0] word;
        word   = addr >> byte_offset;
        f.bank = word & ((MaxFieldBits'(1) << bank_bits) - MaxFieldBits'(1));
        f.tile = (word >> bank_bits) & ((MaxFieldBits'(1) << tile_bits) - MaxFieldBits'(1));
        f.row  = word >> (bank_bits + tile_bits);
        return f;
    endfunction

endpackage

// File: rtl/tcdm_out_reg.sv
// Generic one-entry valid/ready pipeline register; accepts a new entry in
// the same cycle the current one leaves.
module tcdm_out_reg #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o
);

    logic             valid_q;
    logic [Width-1:0] data_q;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_valid_i && in_ready_o) begin
            valid_q <= 1'b1;
            data_q  <= in_data_i;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/tcdm_req_router.sv
// Routes scrambled TCDM requests to local banks or the remote interconnect,
// locking the destination class while responses are outstanding.
module tcdm_req_router
    import tcdm_router_pkg::*;
#(
    parameter int unsigned AddrWidth       = 32,
    parameter int unsigned DataWidth       = 32,
    parameter int unsigned ByteOffset      = 2,
    parameter int unsigned NumTiles        = 16,
    parameter int unsigned NumBanksPerTile = 16,
    parameter int unsigned MaxOutstanding  = 8,
    localparam int unsigned TileIdBits     = tile_id_bits(NumTiles),
    localparam int unsigned BankOffsetBits = bank_offset_bits(NumBanksPerTile),
    localparam int unsigned RowBits        = row_bits(AddrWidth, ByteOffset, NumTiles, NumBanksPerTile)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [TileIdBits-1:0]     tile_id_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [AddrWidth-1:0]      req_addr_i,
    input  logic                      req_wen_i,
    input  logic [DataWidth-1:0]      req_wdata_i,
    input  logic [DataWidth/8-1:0]    req_be_i,
    output logic                      loc_req_valid_o,
    input  logic                      loc_req_ready_i,
    output logic                      rem_req_valid_o,
    input  logic                      rem_req_ready_i,
    output logic [TileIdBits-1:0]     out_tile_o,
    output logic [BankOffsetBits-1:0] out_bank_o,
    output logic [RowBits-1:0]        out_row_o,
    output logic                      out_wen_o,
    output logic [DataWidth-1:0]      out_wdata_o,
    output logic [DataWidth/8-1:0]    out_be_o,
    input  logic                      loc_resp_valid_i,
    input  logic [DataWidth-1:0]      loc_resp_rdata_i,
    input  logic                      rem_resp_valid_i,
    input  logic [DataWidth-1:0]      rem_resp_rdata_i,
    output logic                      resp_valid_o,
    output logic [DataWidth-1:0]      resp_rdata_o
);

    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

    if (!is_pow2(NumTiles) || NumTiles < 2) begin : g_bad_tiles
        $fatal(1, "NumTiles must be a power of 2 and >= 2");
    end
    if (!is_pow2(NumBanksPerTile) || NumBanksPerTile < 2) begin : g_bad_banks
        $fatal(1, "NumBanksPerTile must be a power of 2 and >= 2");
    end
    if (MaxOutstanding == 0) begin : g_bad_outstanding
        $fatal(1, "MaxOutstanding must be >= 1");
    end
    if (AddrWidth > MaxFieldBits ||
        AddrWidth <= ByteOffset + BankOffsetBits + TileIdBits) begin : g_bad_addr
        $fatal(1, "AddrWidth leaves no row bits or exceeds the decoder width");
    end

    typedef struct packed {
        dest_e                     dest;
        logic [TileIdBits-1:0]     tile;
        logic [BankOffsetBits-1:0] bank;
        logic [RowBits-1:0]        row;
        logic                      wen;
        logic [DataWidth-1:0]      wdata;
        logic [DataWidth/8-1:0]    be;
    } req_payload_t;

    addr_fields_t         fields;
    dest_e                req_dest;
    dest_e                dest_q;
    logic                 unused_fields;
    req_payload_t         in_payload;
    req_payload_t         out_payload;
    logic                 reg_in_ready;
    logic                 reg_out_valid;
    logic                 reg_out_ready;
    logic                 accept_ok;
    logic                 req_fire;
    logic                 resp_in;
    logic                 resp_ack;
    logic [CntWidth-1:0]  cnt_q;
    logic                 resp_valid_q;
    logic [DataWidth-1:0] resp_rdata_q;

    assign fields        = decode_addr(MaxFieldBits'(req_addr_i), ByteOffset, BankOffsetBits, TileIdBits);
    assign unused_fields = ^fields;
    assign req_dest      = (fields.tile[TileIdBits-1:0] == tile_id_i) ? LOCAL : REMOTE;

    assign in_payload = '{
        dest:  req_dest,
        tile:  fields.tile[TileIdBits-1:0],
        bank:  fields.bank[BankOffsetBits-1:0],
        row:   fields.row[RowBits-1:0],
        wen:   req_wen_i,
        wdata: req_wdata_i,
        be:    req_be_i
    };

    // A class switch waits for the counter to drain so responses return in order.
    assign accept_ok   = !rst_i && (cnt_q < CntWidth'(MaxOutstanding)) &&
                         ((cnt_q == '0) || (req_dest == dest_q));
    assign req_ready_o = reg_in_ready && accept_ok;
    assign req_fire    = req_valid_i && req_ready_o;

    assign reg_out_ready = (out_payload.dest == LOCAL) ? loc_req_ready_i : rem_req_ready_i;

    tcdm_out_reg #(
        .Width ($bits(req_payload_t))
    ) i_out_reg (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (req_valid_i && accept_ok),
        .in_ready_o  (reg_in_ready),
        .in_data_i   (in_payload),
        .out_valid_o (reg_out_valid),
        .out_ready_i (reg_out_ready),
        .out_data_o  (out_payload)
    );

    assign loc_req_valid_o = reg_out_valid && (out_payload.dest == LOCAL);
    assign rem_req_valid_o = reg_out_valid && (out_payload.dest == REMOTE);
    assign out_tile_o      = out_payload.tile;
    assign out_bank_o      = out_payload.bank;
    assign out_row_o       = out_payload.row;
    assign out_wen_o       = out_payload.wen;
    assign out_wdata_o     = out_payload.wdata;
    assign out_be_o        = out_payload.be;

    // Responses with nothing outstanding are stale and get dropped.
    assign resp_in  = loc_resp_valid_i || rem_resp_valid_i;
    assign resp_ack = resp_in && (cnt_q != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q        <= '0;
            dest_q       <= LOCAL;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            if (req_fire && !resp_ack) begin
                cnt_q <= cnt_q + CntWidth'(1);
            end else if (!req_fire && resp_ack) begin
                cnt_q <= cnt_q - CntWidth'(1);
            end
            if (req_fire) begin
                dest_q <= req_dest;
            end
            resp_valid_q <= resp_ack;
            if (resp_ack) begin
                resp_rdata_q <= loc_resp_valid_i ? loc_resp_rdata_i : rem_resp_rdata_i;
            end
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;

    assert property (@(posedge clk_i) disable iff (rst_i)
                     !(loc_resp_valid_i && rem_resp_valid_i))
        else $error("tcdm_req_router: local and remote responses in the same cycle");

    assert property (@(posedge clk_i) disable iff (rst_i) !(resp_in && cnt_q == '0))
        else $warning("tcdm_req_router: response with nothing outstanding dropped");

endmodule

// File: tb/tb_tcdm_req_router.sv
// Directed scenarios followed by a randomized run against a transaction-level
// model of the router (4 tiles, 4 banks, tile id 1, two outstanding).
module tb_tcdm_req_router;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  tile_id_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic        req_wen_i;
    logic [31:0] req_wdata_i;
    logic [3:0]  req_be_i;
    logic        loc_req_valid_o;
    logic        loc_req_ready_i;
    logic        rem_req_valid_o;
    logic        rem_req_ready_i;
    logic [1:0]  out_tile_o;
    logic [1:0]  out_bank_o;
    logic [25:0] out_row_o;
    logic        out_wen_o;
    logic [31:0] out_wdata_o;
    logic [3:0]  out_be_o;
    logic        loc_resp_valid_i;
    logic [31:0] loc_resp_rdata_i;
    logic        rem_resp_valid_i;
    logic [31:0] rem_resp_rdata_i;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;

    int checks   = 0;
    int failures = 0;

    tcdm_req_router #(
        .AddrWidth       (32),
        .DataWidth       (32),
        .ByteOffset      (2),
        .NumTiles        (4),
        .NumBanksPerTile (4),
        .MaxOutstanding  (2)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .tile_id_i        (tile_id_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_addr_i       (req_addr_i),
        .req_wen_i        (req_wen_i),
        .req_wdata_i      (req_wdata_i),
        .req_be_i         (req_be_i),
        .loc_req_valid_o  (loc_req_valid_o),
        .loc_req_ready_i  (loc_req_ready_i),
        .rem_req_valid_o  (rem_req_valid_o),
        .rem_req_ready_i  (rem_req_ready_i),
        .out_tile_o       (out_tile_o),
        .out_bank_o       (out_bank_o),
        .out_row_o        (out_row_o),
        .out_wen_o        (out_wen_o),
        .out_wdata_o      (out_wdata_o),
        .out_be_o         (out_be_o),
        .loc_resp_valid_i (loc_resp_valid_i),
        .loc_resp_rdata_i (loc_resp_rdata_i),
        .rem_resp_valid_i (rem_resp_valid_i),
        .rem_resp_rdata_i (rem_resp_rdata_i),
        .resp_valid_o     (resp_valid_o),
        .resp_rdata_o     (resp_rdata_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          is_rem;
        logic [1:0]  tile;
        logic [1:0]  bank;
        logic [25:0] row;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    req_t        pend_q[$];
    req_t        new_req;
    int          outstanding;
    bit          cur_rem;
    bit          exp_resp_v;
    logic [31:0] exp_resp_d;
    bit          exp_ready;
    bit          out_fire;
    bit          resp_sent;
    logic [31:0] resp_data;
    logic [1:0]  byte_off;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] addr, input logic lr, input logic rr);
        req_valid_i     = valid;
        req_addr_i      = addr;
        req_wen_i       = addr[2];
        req_wdata_i     = addr ^ 32'hA5A5_5A5A;
        req_be_i        = 4'hF;
        loc_req_ready_i = lr;
        rem_req_ready_i = rr;
    endtask

    task automatic applyResponse(input logic lv, input logic rv, input logic [31:0] data);
        loc_resp_valid_i = lv;
        rem_resp_valid_i = rv;
        loc_resp_rdata_i = lv ? data : ~data;
        rem_resp_rdata_i = rv ? data : ~data;
    endtask

    task automatic checkReq(input string tag, input bit exp_loc, input bit exp_rem,
                            input logic [1:0] tile, input logic [1:0] bank, input logic [25:0] row);
        checkOutput({tag, "_loc_valid"}, loc_req_valid_o, exp_loc);
        checkOutput({tag, "_rem_valid"}, rem_req_valid_o, exp_rem);
        checkOutput({tag, "_tile"}, out_tile_o, tile);
        checkOutput({tag, "_bank"}, out_bank_o, bank);
        checkOutput({tag, "_row"}, out_row_o, row);
    endtask

    initial begin
        rst_i     = 1'b1;
        tile_id_i = 2'd1;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        applyResponse(1'b0, 1'b0, 32'h0);
        tick();
        tick();

        // Reset holds ready low and clears all outputs.
        applyStimulus(1'b1, 32'h0000_0014, 1'b1, 1'b1);
        #1;
        checkOutput("reset_ready", req_ready_o, 1'b0);
        checkReq("reset", 1'b0, 1'b0, 2'd0, 2'd0, 26'd0);
        checkOutput("reset_resp_valid", resp_valid_o, 1'b0);
        rst_i = 1'b0;
        #1;
        checkOutput("ready_after_reset", req_ready_o, 1'b1);
        tick();

        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkReq("local_route", 1'b1, 1'b0, 2'd1, 2'd1, 26'd0);
        checkOutput("local_wen", out_wen_o, 1'b1);
        checkOutput("local_wdata", out_wdata_o, 32'h0000_0014 ^ 32'hA5A5_5A5A);
        checkOutput("local_be", out_be_o, 4'hF);
        applyResponse(1'b1, 1'b0, 32'hDEAD_0001);
        tick();
        applyResponse(1'b0, 1'b0, 32'h0);
        checkOutput("resp1_valid", resp_valid_o, 1'b1);
        checkOutput("resp1_rdata", resp_rdata_o, 32'hDEAD_0001);
        checkOutput("local_drained", loc_req_valid_o, 1'b0);

        applyStimulus(1'b1, 32'h0000_0264, 1'b1, 1'b1);
        #1;
        checkOutput("remote_ready", req_ready_o, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkReq("remote_route", 1'b0, 1'b1, 2'd2, 2'd1, 26'd9);
        checkOutput("resp1_pulse_end", resp_valid_o, 1'b0);
        applyResponse(1'b0, 1'b1, 32'hBEEF_0002);
        tick();
        applyResponse(1'b0, 1'b0, 32'h0);
        checkOutput("resp2_valid", resp_valid_o, 1'b1);
        checkOutput("resp2_rdata", resp_rdata_o, 32'hBEEF_0002);

        // A class switch stalls until the local response has drained the counter.
        applyStimulus(1'b1, 32'h0000_0014, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 32'h0000_0264, 1'b1, 1'b1);
        #1;
        checkOutput("switch_stall", req_ready_o, 1'b0);
        tick();
        checkOutput("switch_stall2", req_ready_o, 1'b0);
        checkOutput("switch_no_remote", rem_req_valid_o, 1'b0);
        applyResponse(1'b1, 1'b0, 32'h1234_0003);
        #1;
        checkOutput("switch_same_cycle_resp", req_ready_o, 1'b0);
        tick();
        applyResponse(1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("switch_unstall", req_ready_o, 1'b1);
        checkOutput("switch_resp_valid", resp_valid_o, 1'b1);
        checkOutput("switch_resp_rdata", resp_rdata_o, 32'h1234_0003);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkReq("switch_remote", 1'b0, 1'b1, 2'd2, 2'd1, 26'd9);
        applyResponse(1'b0, 1'b1, 32'h1234_0004);
        tick();
        applyResponse(1'b0, 1'b0, 32'h0);

        // Two locals fill the outstanding budget; the third waits for one response.
        applyStimulus(1'b1, 32'h0000_0014, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 32'h0000_0018, 1'b1, 1'b1);
        #1;
        checkOutput("second_local_ready", req_ready_o, 1'b1);
        tick();
        applyStimulus(1'b1, 32'h0000_001C, 1'b1, 1'b1);
        #1;
        checkOutput("max_outstanding_stall", req_ready_o, 1'b0);
        tick();
        applyResponse(1'b1, 1'b0, 32'h5555_0005);
        #1;
        checkOutput("max_same_cycle_resp", req_ready_o, 1'b0);
        tick();
        applyResponse(1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("max_unstall", req_ready_o, 1'b1);
        checkOutput("max_resp_valid", resp_valid_o, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("max_resp_pulse_end", resp_valid_o, 1'b0);
        checkReq("third_local", 1'b1, 1'b0, 2'd1, 2'd3, 26'd0);
        applyResponse(1'b1, 1'b0, 32'h5555_0006);
        tick();
        tick();
        applyResponse(1'b0, 1'b0, 32'h0);

        // Downstream backpressure keeps the payload stable and stalls the input.
        applyStimulus(1'b1, 32'h0000_0010, 1'b0, 1'b1);
        #1;
        checkOutput("bp_first_ready", req_ready_o, 1'b1);
        tick();
        applyStimulus(1'b1, 32'h0000_0014, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("bp_input_stall", req_ready_o, 1'b0);
            checkReq("bp_hold", 1'b1, 1'b0, 2'd1, 2'd0, 26'd0);
            tick();
        end
        loc_req_ready_i = 1'b1;
        #1;
        checkOutput("bp_release_ready", req_ready_o, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkReq("bp_single_fire", 1'b1, 1'b0, 2'd1, 2'd1, 26'd0);

        // Reset with two outstanding and the register full.
        rst_i = 1'b1;
        tick();
        checkReq("midrst", 1'b0, 1'b0, 2'd0, 2'd0, 26'd0);
        checkOutput("midrst_ready", req_ready_o, 1'b0);
        checkOutput("midrst_resp_valid", resp_valid_o, 1'b0);
        rst_i = 1'b0;
        applyResponse(1'b1, 1'b0, 32'h7777_0007);
        tick();
        applyResponse(1'b0, 1'b0, 32'h0);
        checkOutput("stale_resp_dropped", resp_valid_o, 1'b0);
        applyStimulus(1'b1, 32'h0000_0264, 1'b1, 1'b1);
        #1;
        checkOutput("midrst_cnt_cleared", req_ready_o, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkReq("after_rst_remote", 1'b0, 1'b1, 2'd2, 2'd1, 26'd9);
        applyResponse(1'b0, 1'b1, 32'h7777_0008);
        tick();
        applyResponse(1'b0, 1'b0, 32'h0);
        tick();

        // Randomized traffic against a transaction-level model.
        outstanding = 0;
        cur_rem     = 1'b0;
        exp_resp_v  = 1'b0;
        exp_resp_d  = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (pend_q.size() != 0) begin
                checkOutput("rnd_loc_valid", loc_req_valid_o, !pend_q[0].is_rem);
                checkOutput("rnd_rem_valid", rem_req_valid_o, pend_q[0].is_rem);
                checkOutput("rnd_tile", out_tile_o, pend_q[0].tile);
                checkOutput("rnd_bank", out_bank_o, pend_q[0].bank);
                checkOutput("rnd_row", out_row_o, pend_q[0].row);
                checkOutput("rnd_wen", out_wen_o, pend_q[0].wen);
                checkOutput("rnd_wdata", out_wdata_o, pend_q[0].wdata);
                checkOutput("rnd_be", out_be_o, pend_q[0].be);
            end else begin
                checkOutput("rnd_idle_loc", loc_req_valid_o, 1'b0);
                checkOutput("rnd_idle_rem", rem_req_valid_o, 1'b0);
            end
            checkOutput("rnd_resp_valid", resp_valid_o, exp_resp_v);
            if (exp_resp_v) begin
                checkOutput("rnd_resp_rdata", resp_rdata_o, exp_resp_d);
            end

            new_req.tile   = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'd1;
            new_req.bank   = 2'($urandom_range(0, 3));
            new_req.row    = 26'($urandom);
            new_req.wen    = 1'($urandom_range(0, 1));
            new_req.wdata  = $urandom;
            new_req.be     = 4'($urandom_range(0, 15));
            new_req.is_rem = (new_req.tile != 2'd1);
            byte_off       = 2'($urandom_range(0, 3));
            req_valid_i     = ($urandom_range(0, 3) != 0);
            req_addr_i      = {new_req.row, new_req.tile, new_req.bank, byte_off};
            req_wen_i       = new_req.wen;
            req_wdata_i     = new_req.wdata;
            req_be_i        = new_req.be;
            loc_req_ready_i = ($urandom_range(0, 3) != 0);
            rem_req_ready_i = ($urandom_range(0, 3) != 0);

            resp_sent = (outstanding - pend_q.size() > 0) && ($urandom_range(0, 1) == 1);
            resp_data = $urandom;
            if (resp_sent && $urandom_range(0, 1) == 1) begin
                applyResponse(1'b1, 1'b0, resp_data);
            end else if (resp_sent) begin
                applyResponse(1'b0, 1'b1, resp_data);
            end else begin
                applyResponse(1'b0, 1'b0, resp_data);
            end
            #1;

            out_fire  = (pend_q.size() != 0) &&
                        (pend_q[0].is_rem ? rem_req_ready_i : loc_req_ready_i);
            exp_ready = ((pend_q.size() == 0) || out_fire) && (outstanding < 2) &&
                        ((outstanding == 0) || (new_req.is_rem == cur_rem));
            checkOutput("rnd_req_ready", req_ready_o, exp_ready);

            if (out_fire) begin
                void'(pend_q.pop_front());
            end
            if (req_valid_i && exp_ready) begin
                pend_q.push_back(new_req);
                cur_rem = new_req.is_rem;
                outstanding++;
            end
            if (resp_sent) begin
                outstanding--;
            end
            exp_resp_v = resp_sent;
            exp_resp_d = resp_data;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
